crc8_serial_engine: RTL and testbench

Bit-serial CRC engine that accumulates an XOR-feedback LFSR over a framed input bit stream and presents the final checksum and frame length on a valid/ready output. It sits downstream of the XOR gate primitives, using XOR as its feedback element, and feeds link-level framing and checking logic. One frame is processed at a time. The result is held until the consumer accepts it.

---
 rtl/crc8_serial_engine.sv | 111 +++++++++++
 tb/tb_crc8_serial_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial_engine
//  Description : Bit-serial CRC engine. Accumulates an MSB-first XOR-feedback
//                LFSR over a framed bit stream and presents the final CRC and
//                a saturating frame length on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial_engine #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h07,
    parameter logic [WIDTH-1:0] INIT  = 8'h00,
    parameter int               LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_crc,
    output logic [LEN_W-1:0] out_len
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] crc_q,   crc_d;
    logic [LEN_W-1:0] len_q,   len_d;

    logic             accept;
    logic             fb;
    logic [WIDTH-1:0] crc_next;
    logic [LEN_W-1:0] len_next;

    // Handshake flags decoded from state only, so no input reaches them combinationally
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state_q == ST_HOLD) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
        end
    end

    // One LFSR step and saturating length increment for the bit on the input
    always_comb begin
        accept   = in_valid && in_ready;
        fb       = crc_q[WIDTH-1] ^ in_bit;
        crc_next = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : {WIDTH{1'b0}});
        len_next = (len_q == LEN_MAX) ? len_q : (len_q + LEN_ONE);
    end

    // Next-state logic: shift while accepting, freeze in HOLD, reload on handshake
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (accept) begin
                    crc_d   = crc_next;
                    len_d   = len_next;
                    state_d = in_last ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    crc_d   = INIT;
                    len_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                crc_d   = INIT;
                len_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
        end
    end

    // Live register values are presented; they are only meaningful in HOLD
    always_comb begin
        out_crc = crc_q;
        out_len = len_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_crc8_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc8_serial_engine
//  Description : Self-checking bench for crc8_serial_engine. Expected CRCs
//                come from polynomial long division of the augmented message.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc8_serial_engine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_crc;
    logic [15:0] out_len;

    int checks;
    int errors;
    bit frame_bits[$];

    crc8_serial_engine #(
        .WIDTH (8),
        .POLY  (8'h07),
        .INIT  (8'h00),
        .LEN_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_len   (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1 (init 0, no final xor)
    function automatic logic [7:0] model_crc();
        int rem;
        int n;
        int b;
        rem = 0;
        n   = frame_bits.size();
        for (int i = 0; i < n + 8; i++) begin
            b   = (i < n) ? int'(frame_bits[i]) : 0;
            rem = (rem << 1) | b;
            if ((rem & 'h100) != 0) rem = rem ^ 'h107;
        end
        return rem[7:0];
    endfunction

    function automatic logic [15:0] model_len();
        int n;
        n = frame_bits.size();
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) frame_bits.push_back(b[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive frame_bits with random idle gaps, then check the held result
    task automatic send_frame(input string name, input int max_gap, input bit do_ack);
        logic [7:0]  exp_crc;
        logic [15:0] exp_len;
        int          n;
        int          gaps;
        exp_crc = model_crc();
        exp_len = model_len();
        n       = frame_bits.size();
        for (int i = 0; i < n; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(1, 0));
                in_last  = 1'($urandom_range(1, 0));
                tick();
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s in_ready bit %0d: got %b want 1", name, i, in_ready);
            end
            in_valid = 1'b1;
            in_bit   = frame_bits[i];
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold flags: got out_valid=%b in_ready=%b want 1/0", name, out_valid, in_ready);
        end
        checks++;
        if (out_crc !== exp_crc) begin
            errors++;
            $display("FAIL %s crc: got %h want %h", name, out_crc, exp_crc);
        end
        checks++;
        if (out_len !== exp_len) begin
            errors++;
            $display("FAIL %s len: got %0d want %0d", name, out_len, exp_len);
        end
        if (do_ack) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_crc !== 8'h00 || out_len !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b crc=%h len=%0d want 1/0/00/0",
                     in_ready, out_valid, out_crc, out_len);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_bytes();
        frame_bits.delete();
        push_byte(8'h01);
        if (model_crc() !== 8'h07) $display("note: model disagrees with known vector for 0x01");
        send_frame("byte01", 0, 1'b1);
        checks++;
        frame_bits.delete();
        push_byte(8'hFF);
        send_frame("byteFF", 0, 1'b1);
    endtask

    task automatic test_check_string();
        frame_bits.delete();
        for (int c = 8'h31; c <= 8'h39; c++) push_byte(8'(c));
        send_frame("check_string", 3, 1'b1);
        // repeat with a different gap pattern; result must not depend on gaps
        send_frame("check_string_gaps", 5, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0]  crc0;
        logic [15:0] len0;
        frame_bits.delete();
        frame_bits.push_back(1'b1);
        send_frame("one_bit", 0, 1'b0);
        crc0 = out_crc;
        len0 = out_len;
        checks++;
        if (crc0 !== 8'h07 || len0 !== 16'd1) begin
            errors++;
            $display("FAIL one_bit_vector: got crc=%h len=%0d want 07/1", crc0, len0);
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(1, 0));
            in_bit   = 1'($urandom_range(1, 0));
            in_last  = 1'($urandom_range(1, 0));
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_crc !== 8'h07 || out_len !== 16'd1) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got rdy=%b vld=%b crc=%h len=%0d want 0/1/07/1",
                         k, in_ready, out_valid, out_crc, out_len);
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    // Two 0x01 frames streamed whenever in_ready is high, out_ready tied high
    task automatic test_back_to_back();
        bit stream[16];
        int idx;
        bit exp_v;
        for (int i = 0; i < 16; i++) stream[i] = ((i % 8) == 7);
        idx       = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_v = (k == 8) || (k == 17);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL b2b out_valid cycle %0d: got %b want %b", k, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_crc !== 8'h07 || out_len !== 16'd8) begin
                    errors++;
                    $display("FAIL b2b result cycle %0d: got crc=%h len=%0d want 07/8", k, out_crc, out_len);
                end
            end
            if (in_ready && idx < 16) begin
                in_valid = 1'b1;
                in_bit   = stream[idx];
                in_last  = ((idx % 8) == 7);
                idx++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_mid_frame_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_crc !== 8'h00 || out_len !== 16'd0) begin
            errors++;
            $display("FAIL midframe_async_reset: got rdy=%b crc=%h len=%0d want 1/00/0", in_ready, out_crc, out_len);
        end
        rst_n = 1'b1;
        tick();
        frame_bits.delete();
        push_byte(8'h01);
        send_frame("after_abort", 0, 1'b1);
    endtask

    task automatic test_reset_in_hold();
        frame_bits.delete();
        push_byte(8'hA5);
        send_frame("pre_reset_hold", 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_crc !== 8'h00 || out_len !== 16'd0) begin
            errors++;
            $display("FAIL hold_async_reset: got vld=%b rdy=%b crc=%h len=%0d want 0/1/00/0",
                     out_valid, in_ready, out_crc, out_len);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_reset_no_output: got vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 6; f++) begin
            frame_bits.delete();
            n = int'($urandom_range(40, 1));
            for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom_range(1, 0)));
            send_frame($sformatf("random%0d", f), 2, 1'b1);
        end
    endtask

    task automatic test_saturation();
        frame_bits.delete();
        for (int i = 0; i < 70000; i++) frame_bits.push_back(1'b0);
        send_frame("saturation", 0, 1'b1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_bytes();
        test_check_string();
        test_backpressure();
        test_back_to_back();
        test_mid_frame_reset();
        test_reset_in_hold();
        test_random_frames();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
